return_addr_stack: RTL and testbench



---
 rtl/return_addr_stack_if.sv | 47 ++++
 rtl/return_addr_stack.sv | 126 ++++++++++++
 tb/tb_return_addr_stack.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/return_addr_stack_if.sv
// return_addr_stack_if -- decode-side connection of the hardware call/return stack.
//
// Parameters:
//   ADDR_W : width of a stored return address
//   DEPTH  : number of stack entries (sets the width of count)
//
// Signals (direction given from the stack's point of view, modport slave):
//   push, pop      in   CALL / RET strobes from decode
//   push_addr      in   return address to store (PC+1 of the CALL)
//   stall          in   hazard stall; push/pop ignored while high
//   clear          in   synchronous flush of the whole stack
//   ret_addr       out  top-of-stack address, 0 when empty
//   ret_valid      out  stack holds at least one entry
//   empty, full    out  occupancy status
//   count          out  current occupancy
//   overflow       out  sticky: push made while full
//   underflow      out  sticky: pop made while empty
// modport master is the pipeline/control side, modport slave is the stack.
interface return_addr_stack_if #(
   parameter int unsigned ADDR_W = 19,
   parameter int unsigned DEPTH  = 8
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_addr;
   logic              stall;
   logic              clear;
   logic [ADDR_W-1:0] ret_addr;
   logic              ret_valid;
   logic              empty;
   logic              full;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, pop, push_addr, stall, clear,
      input  ret_addr, ret_valid, empty, full, count, overflow, underflow
   );

   modport slave (
      input  push, pop, push_addr, stall, clear,
      output ret_addr, ret_valid, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack -- hardware call/return stack beside the ID stage.
//
// Stores return addresses on CALL (push) and presents the top-of-stack address
// to the fetch redirect on RET (pop). ret_addr is combinational from storage, so
// the pipeline reads it in the same cycle pop is asserted; the entry is removed
// at that cycle's rising edge.
//
// Per-edge priority: clear > stall > push/pop.
//   push+pop with entries present replaces the top entry in place.
//   push+pop on an empty stack performs the push and flags underflow.
//   overflow/underflow are sticky until clear or reset.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   ras   : return_addr_stack_if.slave (strobes in, stack status out)
//
// Parameters:
//   ADDR_W : return address width (19)
//   DEPTH  : entries, power of two >= 2 (8)
//   CNT_W  : derived occupancy counter width, $clog2(DEPTH)+1
//
// Build option:
//   RAS_WRAP_EN defined   : push while full overwrites the oldest entry
//                           circularly (count stays DEPTH, overflow set).
//   RAS_WRAP_EN undefined : push while full is dropped (overflow set).
module return_addr_stack #(
   parameter int unsigned ADDR_W = 19,
   parameter int unsigned DEPTH  = 8
) (
   input logic                        clk,
   input logic                        rst_n,
   return_addr_stack_if.slave         ras
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  sp_q, sp_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic [PTR_W-1:0]  top_idx;
   logic              is_empty;
   logic              is_full;

   // sp points at the next free slot; DEPTH is a power of two so the
   // subtraction wraps modulo DEPTH naturally.
   assign top_idx  = sp_q - 1'b1;
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);

   always_comb begin
      mem_d       = mem_q;
      sp_d        = sp_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (ras.clear) begin
         // Entry contents are left as-is; count=0 hides them.
         sp_d        = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else if (!ras.stall) begin
         if (ras.push && ras.pop) begin
            if (is_empty) begin
               mem_d[sp_q] = ras.push_addr;
               sp_d        = sp_q + 1'b1;
               count_d     = count_q + 1'b1;
               underflow_d = 1'b1;
            end else begin
               mem_d[top_idx] = ras.push_addr;
            end
         end else if (ras.push) begin
            if (!is_full) begin
               mem_d[sp_q] = ras.push_addr;
               sp_d        = sp_q + 1'b1;
               count_d     = count_q + 1'b1;
            end else begin
               overflow_d = 1'b1;
`ifdef RAS_WRAP_EN
               // When full, sp also addresses the oldest entry.
               mem_d[sp_q] = ras.push_addr;
               sp_d        = sp_q + 1'b1;
`endif
            end
         end else if (ras.pop) begin
            if (!is_empty) begin
               sp_d    = top_idx;
               count_d = count_q - 1'b1;
            end else begin
               underflow_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q       <= '{default: '0};
         sp_q        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         sp_q        <= sp_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign ras.ret_addr  = is_empty ? '0 : mem_q[top_idx];
   assign ras.ret_valid = !is_empty;
   assign ras.empty     = is_empty;
   assign ras.full      = is_full;
   assign ras.count     = count_q;
   assign ras.overflow  = overflow_q;
   assign ras.underflow = underflow_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack -- directed bench for return_addr_stack at DEPTH=4.
// Inputs are driven after the falling edge; outputs are sampled #1 after the
// rising edge (or just before it for the same-cycle ret_addr reads).
// Overflow expectations follow RAS_WRAP_EN when the bench is built with it.
module tb_return_addr_stack;
   localparam int unsigned ADDR_W = 19;
   localparam int unsigned DEPTH  = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   return_addr_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) ras_if ();

   return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ras   (ras_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of strobes, clock it, release strobes at the falling edge.
   task automatic step(input logic push, input logic pop, input logic [ADDR_W-1:0] addr,
                       input logic stall, input logic clear);
      ras_if.push      = push;
      ras_if.pop       = pop;
      ras_if.push_addr = addr;
      ras_if.stall     = stall;
      ras_if.clear     = clear;
      @(posedge clk);
      #1;
      @(negedge clk);
      ras_if.push  = 1'b0;
      ras_if.pop   = 1'b0;
      ras_if.stall = 1'b0;
      ras_if.clear = 1'b0;
   endtask

   task automatic do_push(input logic [ADDR_W-1:0] addr);
      step(1'b1, 1'b0, addr, 1'b0, 1'b0);
   endtask

   // Pop while checking the same-cycle top-of-stack value before the edge.
   task automatic pop_check(input string tag, input logic [ADDR_W-1:0] exp_top);
      ras_if.pop = 1'b1;
      #1;
      check_eq(tag, 32'(ras_if.ret_addr), 32'(exp_top));
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n            = 1'b0;
      ras_if.push      = 1'b0;
      ras_if.pop       = 1'b0;
      ras_if.push_addr = '0;
      ras_if.stall     = 1'b0;
      ras_if.clear     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      check_eq("rst_count",     32'(ras_if.count), 32'd0);
      check_eq("rst_ret_addr",  32'(ras_if.ret_addr), 32'd0);
      check_eq("rst_ret_valid", 32'(ras_if.ret_valid), 32'd0);
      check_eq("rst_empty",     32'(ras_if.empty), 32'd1);
      check_eq("rst_full",      32'(ras_if.full), 32'd0);
      check_eq("rst_overflow",  32'(ras_if.overflow), 32'd0);
      check_eq("rst_underflow", 32'(ras_if.underflow), 32'd0);

      // Three pushes
      do_push(19'h00010);
      do_push(19'h00020);
      do_push(19'h00030);
      check_eq("p3_count",     32'(ras_if.count), 32'd3);
      check_eq("p3_ret_addr",  32'(ras_if.ret_addr), 32'h00030);
      check_eq("p3_empty",     32'(ras_if.empty), 32'd0);
      check_eq("p3_full",      32'(ras_if.full), 32'd0);
      check_eq("p3_ret_valid", 32'(ras_if.ret_valid), 32'd1);

      // Three pops, top read in the pop cycle
      pop_check("pop1_top", 19'h00030);
      pop_check("pop2_top", 19'h00020);
      pop_check("pop3_top", 19'h00010);
      check_eq("pop3_count",    32'(ras_if.count), 32'd0);
      check_eq("pop3_empty",    32'(ras_if.empty), 32'd1);
      check_eq("pop3_ret_addr", 32'(ras_if.ret_addr), 32'd0);

      // Underflow then clear
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check_eq("uf_flag",  32'(ras_if.underflow), 32'd1);
      check_eq("uf_count", 32'(ras_if.count), 32'd0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check_eq("clr_underflow", 32'(ras_if.underflow), 32'd0);

      // Overflow
      for (int unsigned i = 1; i <= 5; i++) do_push(ADDR_W'(i));
      check_eq("of_count", 32'(ras_if.count), 32'd4);
      check_eq("of_full",  32'(ras_if.full), 32'd1);
      check_eq("of_flag",  32'(ras_if.overflow), 32'd1);
`ifdef RAS_WRAP_EN
      check_eq("of_ret_addr", 32'(ras_if.ret_addr), 32'h5);
      pop_check("of_pop1", 19'h5);
      pop_check("of_pop2", 19'h4);
      pop_check("of_pop3", 19'h3);
      pop_check("of_pop4", 19'h2);
`else
      check_eq("of_ret_addr", 32'(ras_if.ret_addr), 32'h4);
      pop_check("of_pop1", 19'h4);
      pop_check("of_pop2", 19'h3);
      pop_check("of_pop3", 19'h2);
      pop_check("of_pop4", 19'h1);
`endif
      check_eq("of_drain_empty", 32'(ras_if.empty), 32'd1);
      check_eq("of_flag_sticky", 32'(ras_if.overflow), 32'd1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check_eq("clr_overflow", 32'(ras_if.overflow), 32'd0);

      // Simultaneous push+pop replaces top; stall blocks updates
      do_push(19'h00010);
      do_push(19'h00020);
      step(1'b1, 1'b1, 19'h7FFFF, 1'b0, 1'b0);
      check_eq("pp_count",    32'(ras_if.count), 32'd2);
      check_eq("pp_ret_addr", 32'(ras_if.ret_addr), 32'h7FFFF);
      step(1'b0, 1'b1, '0, 1'b1, 1'b0);
      check_eq("stall_pop_count",    32'(ras_if.count), 32'd2);
      check_eq("stall_pop_ret_addr", 32'(ras_if.ret_addr), 32'h7FFFF);
      step(1'b1, 1'b0, 19'h01234, 1'b1, 1'b0);
      check_eq("stall_push_count",    32'(ras_if.count), 32'd2);
      check_eq("stall_push_ret_addr", 32'(ras_if.ret_addr), 32'h7FFFF);
      pop_check("pp_pop1", 19'h7FFFF);
      check_eq("pp_below_top", 32'(ras_if.ret_addr), 32'h00010);

      // Clear beats stall
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      check_eq("clr_over_stall", 32'(ras_if.count), 32'd0);

      // push+pop on empty: push happens, underflow set
      step(1'b1, 1'b1, 19'h00123, 1'b0, 1'b0);
      check_eq("ppe_count",     32'(ras_if.count), 32'd1);
      check_eq("ppe_ret_addr",  32'(ras_if.ret_addr), 32'h00123);
      check_eq("ppe_underflow", 32'(ras_if.underflow), 32'd1);

      // Asynchronous reset mid-operation
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      do_push(19'h00AAA);
      check_eq("ar_pre_count", 32'(ras_if.count), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ar_count",    32'(ras_if.count), 32'd0);
      check_eq("ar_ret_addr", 32'(ras_if.ret_addr), 32'd0);
      check_eq("ar_empty",    32'(ras_if.empty), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ar_post_count", 32'(ras_if.count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
